// File: rtl/w1_commit_if.sv
// W1 stage commit bus: W1 register contents and divider result in,
// stall/issue feedback and registered architectural-state write ports out.
interface w1_commit_if;
  logic        W1_M2Issued, W1_Flush, W1_M2Exception;
  logic [4:0]  W1_M2ExcCode;
  logic [31:0] W1_RestartPC;
  logic        W1_IsBDS;
  logic [31:0] W1_BadVAddr;
  logic [4:0]  W1_RtRd;
  logic        W1_RegWrite, W1_HiWrite, W1_LoWrite, W1_MemToReg, W1_Div, W1_ICacheOp, W1_Eret;
  logic [31:0] W1_ALUResult, W1_ReadData;
  logic        Div_Done;
  logic [31:0] Div_Hi, Div_Lo;
  logic        W1_Stall, W1_Issued, ICache_Go;
  logic        W2_RegWrite;
  logic [4:0]  W2_RtRd;
  logic [31:0] W2_WriteData;
  logic        W2_HiWrite, W2_LoWrite;
  logic [31:0] W2_Hi, W2_Lo;
  logic        Exc_Valid;
  logic [4:0]  Exc_Code;
  logic [31:0] Exc_EPC;
  logic        Exc_BD;
  logic [31:0] Exc_BadVAddr;
  logic        Eret_Commit;

  modport master (
    output W1_M2Issued, W1_Flush, W1_M2Exception, W1_M2ExcCode, W1_RestartPC, W1_IsBDS,
           W1_BadVAddr, W1_RtRd, W1_RegWrite, W1_HiWrite, W1_LoWrite, W1_MemToReg, W1_Div,
           W1_ICacheOp, W1_Eret, W1_ALUResult, W1_ReadData, Div_Done, Div_Hi, Div_Lo,
    input  W1_Stall, W1_Issued, ICache_Go, W2_RegWrite, W2_RtRd, W2_WriteData, W2_HiWrite,
           W2_LoWrite, W2_Hi, W2_Lo, Exc_Valid, Exc_Code, Exc_EPC, Exc_BD, Exc_BadVAddr,
           Eret_Commit
  );

  modport slave (
    input  W1_M2Issued, W1_Flush, W1_M2Exception, W1_M2ExcCode, W1_RestartPC, W1_IsBDS,
           W1_BadVAddr, W1_RtRd, W1_RegWrite, W1_HiWrite, W1_LoWrite, W1_MemToReg, W1_Div,
           W1_ICacheOp, W1_Eret, W1_ALUResult, W1_ReadData, Div_Done, Div_Hi, Div_Lo,
    output W1_Stall, W1_Issued, ICache_Go, W2_RegWrite, W2_RtRd, W2_WriteData, W2_HiWrite,
           W2_LoWrite, W2_Hi, W2_Lo, Exc_Valid, Exc_Code, Exc_EPC, Exc_BD, Exc_BadVAddr,
           Eret_Commit
  );
endinterface

// File: rtl/w1_commit.sv
// Writeback commit controller: decides retire/stall/trap for the W1 instruction
// and registers the GPR, HI/LO, exception and ERET commit ports.
module w1_commit (
  input  logic        clock,
  input  logic        reset,
  w1_commit_if.slave  bus
);
  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] DIV_WAIT = 2'd1;
  localparam logic [1:0] ICACHE2  = 2'd2;

  logic [1:0] state, state_nxt;
  logic       v, trap, retire, stall, go;

  always_comb begin
    v         = bus.W1_M2Issued & ~bus.W1_Flush;
    state_nxt = state;
    trap      = 1'b0;
    retire    = 1'b0;
    stall     = 1'b0;
    go        = 1'b0;
    case (state)
      RUN: begin
        if (v & bus.W1_M2Exception) trap = 1'b1;
        else if (v & bus.W1_Div & ~bus.Div_Done) begin
          stall     = 1'b1;
          state_nxt = DIV_WAIT;
        end else if (v & bus.W1_ICacheOp) begin
          stall     = 1'b1;
          go        = 1'b1;
          state_nxt = ICACHE2;
        end else if (v) retire = 1'b1;
      end
      DIV_WAIT: begin
        if (bus.W1_Flush) state_nxt = RUN;
        else if (bus.Div_Done) begin
          retire    = 1'b1;
          state_nxt = RUN;
        end else stall = 1'b1;
      end
      ICACHE2: begin
        // The launch already went out; a flush here only cancels the retire.
        retire    = ~bus.W1_Flush;
        state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  assign bus.W1_Stall  = reset & stall;
  assign bus.W1_Issued = reset & (trap | retire);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= RUN;
      bus.ICache_Go    <= 1'b0;
      bus.W2_RegWrite  <= 1'b0;
      bus.W2_RtRd      <= '0;
      bus.W2_WriteData <= '0;
      bus.W2_HiWrite   <= 1'b0;
      bus.W2_LoWrite   <= 1'b0;
      bus.W2_Hi        <= '0;
      bus.W2_Lo        <= '0;
      bus.Exc_Valid    <= 1'b0;
      bus.Exc_Code     <= '0;
      bus.Exc_EPC      <= '0;
      bus.Exc_BD       <= 1'b0;
      bus.Exc_BadVAddr <= '0;
      bus.Eret_Commit  <= 1'b0;
    end else begin
      state           <= state_nxt;
      bus.ICache_Go   <= go;
      bus.W2_RegWrite <= retire & bus.W1_RegWrite & (bus.W1_RtRd != 5'd0);
      bus.W2_HiWrite  <= retire & bus.W1_HiWrite;
      bus.W2_LoWrite  <= retire & bus.W1_LoWrite;
      bus.Eret_Commit <= retire & bus.W1_Eret;
      bus.Exc_Valid   <= trap;
      if (retire) begin
        bus.W2_RtRd      <= bus.W1_RtRd;
        bus.W2_WriteData <= bus.W1_MemToReg ? bus.W1_ReadData : bus.W1_ALUResult;
        bus.W2_Hi        <= bus.W1_Div ? bus.Div_Hi : bus.W1_ALUResult;
        bus.W2_Lo        <= bus.W1_Div ? bus.Div_Lo : bus.W1_ALUResult;
      end
      if (trap) begin
        bus.Exc_Code     <= bus.W1_M2ExcCode;
        bus.Exc_EPC      <= bus.W1_RestartPC;
        bus.Exc_BD       <= bus.W1_IsBDS;
        bus.Exc_BadVAddr <= bus.W1_BadVAddr;
      end
    end
  end
endmodule

// File: tb/tb_w1_commit.sv
// Self-checking bench for w1_commit: directed scenarios plus randomized
// instructions checked against a transaction-level commit model.
module tb_w1_commit;
  logic clock = 1'b0;
  logic reset;
  int   n_cmp = 0, n_fail = 0;

  w1_commit_if bus();
  w1_commit dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  typedef struct {
    logic exc; logic [4:0] code; logic [31:0] pc; logic bds; logic [31:0] bva;
    logic [4:0] rd; logic rw, hw, lw, m2r, div, ic, eret;
    logic [31:0] alu, rdata, dhi, dlo;
  } instr_t;

  typedef struct {
    logic reg_we; logic [4:0] rd; logic [31:0] wdata;
    logic hi_we, lo_we; logic [31:0] hi, lo;
    logic exc; logic [4:0] code; logic [31:0] epc; logic bd; logic [31:0] bva;
    logic eret;
  } obs_t;

  function automatic instr_t nop_instr();
    instr_t i;
    i = '{exc:0, code:0, pc:0, bds:0, bva:0, rd:0, rw:0, hw:0, lw:0, m2r:0,
          div:0, ic:0, eret:0, alu:0, rdata:0, dhi:0, dlo:0};
    return i;
  endfunction

  // What the architectural state should see once the instruction leaves W1.
  function automatic obs_t model(input instr_t i);
    obs_t e;
    e = '{reg_we:0, rd:0, wdata:0, hi_we:0, lo_we:0, hi:0, lo:0,
          exc:0, code:0, epc:0, bd:0, bva:0, eret:0};
    if (i.exc) begin
      e.exc = 1; e.code = i.code; e.epc = i.pc; e.bd = i.bds; e.bva = i.bva;
    end else begin
      e.reg_we = i.rw && (i.rd != 0);
      e.rd     = i.rd;
      e.wdata  = i.m2r ? i.rdata : i.alu;
      e.hi_we  = i.hw;
      e.lo_we  = i.lw;
      e.hi     = i.div ? i.dhi : i.alu;
      e.lo     = i.div ? i.dlo : i.alu;
      e.eret   = i.eret;
    end
    return e;
  endfunction

  function automatic int model_stalls(input instr_t i, input int dd);
    if (i.exc) return 0;
    if (i.div) return dd;
    if (i.ic)  return 1;
    return 0;
  endfunction

  task automatic idle();
    bus.W1_M2Issued = 0; bus.W1_Flush = 0; bus.W1_M2Exception = 0; bus.W1_M2ExcCode = 0;
    bus.W1_RestartPC = 0; bus.W1_IsBDS = 0; bus.W1_BadVAddr = 0; bus.W1_RtRd = 0;
    bus.W1_RegWrite = 0; bus.W1_HiWrite = 0; bus.W1_LoWrite = 0; bus.W1_MemToReg = 0;
    bus.W1_Div = 0; bus.W1_ICacheOp = 0; bus.W1_Eret = 0; bus.W1_ALUResult = 0;
    bus.W1_ReadData = 0; bus.Div_Done = 0; bus.Div_Hi = 0; bus.Div_Lo = 0;
  endtask

  task automatic apply(input instr_t i);
    bus.W1_M2Issued = 1; bus.W1_Flush = 0; bus.W1_M2Exception = i.exc; bus.W1_M2ExcCode = i.code;
    bus.W1_RestartPC = i.pc; bus.W1_IsBDS = i.bds; bus.W1_BadVAddr = i.bva; bus.W1_RtRd = i.rd;
    bus.W1_RegWrite = i.rw; bus.W1_HiWrite = i.hw; bus.W1_LoWrite = i.lw; bus.W1_MemToReg = i.m2r;
    bus.W1_Div = i.div; bus.W1_ICacheOp = i.ic; bus.W1_Eret = i.eret; bus.W1_ALUResult = i.alu;
    bus.W1_ReadData = i.rdata; bus.Div_Hi = i.dhi; bus.Div_Lo = i.dlo;
  endtask

  task automatic sample(output obs_t o);
    o.reg_we = bus.W2_RegWrite; o.rd = bus.W2_RtRd; o.wdata = bus.W2_WriteData;
    o.hi_we = bus.W2_HiWrite; o.lo_we = bus.W2_LoWrite; o.hi = bus.W2_Hi; o.lo = bus.W2_Lo;
    o.exc = bus.Exc_Valid; o.code = bus.Exc_Code; o.epc = bus.Exc_EPC; o.bd = bus.Exc_BD;
    o.bva = bus.Exc_BadVAddr; o.eret = bus.Eret_Commit;
  endtask

  // Holds the instruction in W1 until it issues; Div_Done rises dd cycles in.
  task automatic drive(input instr_t in, input int dd, output int stalls, output int go_cnt,
                       output int icyc, output obs_t got);
    logic iss;
    apply(in);
    bus.Div_Done = in.div && (dd == 0);
    stalls = 0; go_cnt = 0; icyc = -1;
    for (int c = 0; c < 20 && icyc < 0; c++) begin
      #1;
      n_cmp++;
      if (bus.W1_Stall && bus.W1_Issued) begin
        n_fail++; $display("FAIL stall_issued_excl cyc %0d: got both high, required at most one", c);
      end
      iss = bus.W1_Issued;
      stalls += int'(bus.W1_Stall);
      @(posedge clock); #1;
      go_cnt += int'(bus.ICache_Go);
      if (iss) icyc = c;
      else bus.Div_Done = in.div && (c + 1 >= dd);
    end
    n_cmp++;
    if (icyc < 0) begin n_fail++; $display("FAIL issue_timeout: got no W1_Issued in 20 cycles, required one"); end
    sample(got);
    idle();
  endtask

  task automatic check_quiet(input string tag);
    @(posedge clock); #1;
    n_cmp++;
    if ({bus.W2_RegWrite, bus.W2_HiWrite, bus.W2_LoWrite, bus.Exc_Valid, bus.Eret_Commit, bus.ICache_Go} !== 6'b0) begin
      n_fail++;
      $display("FAIL %s_quiet: got strobes %b, required 000000", tag,
               {bus.W2_RegWrite, bus.W2_HiWrite, bus.W2_LoWrite, bus.Exc_Valid, bus.Eret_Commit, bus.ICache_Go});
    end
  endtask

  task automatic check_all_zero(input string tag);
    n_cmp++;
    if ({bus.W1_Stall, bus.W1_Issued, bus.ICache_Go, bus.W2_RegWrite, bus.W2_RtRd, bus.W2_WriteData,
         bus.W2_HiWrite, bus.W2_LoWrite, bus.W2_Hi, bus.W2_Lo, bus.Exc_Valid, bus.Exc_Code, bus.Exc_EPC,
         bus.Exc_BD, bus.Exc_BadVAddr, bus.Eret_Commit} !== '0) begin
      n_fail++;
      $display("FAIL %s: got stall=%b issued=%b go=%b rw=%b wd=%h hi=%h lo=%h exc=%b epc=%h, required all 0",
               tag, bus.W1_Stall, bus.W1_Issued, bus.ICache_Go, bus.W2_RegWrite, bus.W2_WriteData,
               bus.W2_Hi, bus.W2_Lo, bus.Exc_Valid, bus.Exc_EPC);
    end
  endtask

  task automatic test_reset();
    instr_t in; obs_t got; int st, gc, ic;
    idle();
    reset = 1'b1; #1 reset = 1'b0;
    repeat (2) @(posedge clock); #1;
    check_all_zero("reset_poweron");
    reset = 1'b1;
    // Stop a divide in DIV_WAIT, then pull reset asynchronously.
    in = nop_instr(); in.div = 1; in.hw = 1; in.lw = 1; in.dhi = 32'h11; in.dlo = 32'h22;
    @(posedge clock); #1;
    apply(in); bus.Div_Done = 0;
    repeat (3) @(posedge clock);
    #2 reset = 1'b0; #1;
    check_all_zero("reset_mid_div");
    @(posedge clock); #1;
    idle(); reset = 1'b1;
    in = nop_instr(); in.rw = 1; in.rd = 5'd3; in.alu = 32'h1234_5678;
    drive(in, 0, st, gc, ic, got);
    n_cmp++;
    if (st !== 0 || ic !== 0) begin n_fail++; $display("FAIL reset_first_retire: got stalls=%0d issue_cyc=%0d, required 0/0", st, ic); end
    n_cmp++;
    if ({got.reg_we, got.rd, got.wdata} !== {1'b1, 5'd3, 32'h1234_5678}) begin
      n_fail++; $display("FAIL reset_first_write: got we=%b rd=%0d wd=%h, required 1/3/12345678", got.reg_we, got.rd, got.wdata);
    end
  endtask

  task automatic test_normal_retire();
    instr_t in; obs_t got; int st, gc, ic;
    in = nop_instr(); in.rw = 1; in.rd = 5'd5; in.m2r = 1; in.rdata = 32'hDEAD_BEEF; in.alu = 32'h0BAD_0BAD;
    drive(in, 0, st, gc, ic, got);
    n_cmp++;
    if ({got.reg_we, got.rd, got.wdata} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL normal_write: got we=%b rd=%0d wd=%h, required 1/5/deadbeef", got.reg_we, got.rd, got.wdata);
    end
    check_quiet("normal");
    in.rd = 5'd0;
    drive(in, 0, st, gc, ic, got);
    n_cmp++;
    if (got.reg_we !== 1'b0) begin n_fail++; $display("FAIL normal_r0: got W2_RegWrite=%b, required 0", got.reg_we); end
  endtask

  task automatic test_exception();
    instr_t in; obs_t got; int st, gc, ic;
    in = nop_instr(); in.exc = 1; in.code = 5'h04; in.pc = 32'h8000_0180; in.bds = 1;
    in.bva = 32'h0000_1003; in.rw = 1; in.rd = 5'd9; in.div = 1; in.hw = 1;
    drive(in, 2, st, gc, ic, got);
    n_cmp++;
    if (st !== 0 || ic !== 0) begin n_fail++; $display("FAIL exc_issue: got stalls=%0d issue_cyc=%0d, required 0/0", st, ic); end
    n_cmp++;
    if ({got.exc, got.code, got.epc, got.bd, got.bva} !== {1'b1, 5'h04, 32'h8000_0180, 1'b1, 32'h0000_1003}) begin
      n_fail++; $display("FAIL exc_commit: got v=%b code=%h epc=%h bd=%b bva=%h, required 1/04/80000180/1/00001003",
                         got.exc, got.code, got.epc, got.bd, got.bva);
    end
    n_cmp++;
    if ({got.reg_we, got.hi_we, got.lo_we} !== 3'b0) begin
      n_fail++; $display("FAIL exc_nowrite: got writes %b, required 000", {got.reg_we, got.hi_we, got.lo_we});
    end
    check_quiet("exc");
  endtask

  task automatic test_div_wait();
    instr_t in; obs_t got; int st, gc, ic;
    in = nop_instr(); in.div = 1; in.hw = 1; in.lw = 1; in.dhi = 32'd7; in.dlo = 32'd9; in.alu = 32'hFFFF;
    drive(in, 3, st, gc, ic, got);
    n_cmp++;
    if (st !== 3 || ic !== 3) begin n_fail++; $display("FAIL div_stall: got stalls=%0d issue_cyc=%0d, required 3/3", st, ic); end
    n_cmp++;
    if ({got.hi_we, got.lo_we, got.hi, got.lo} !== {1'b1, 1'b1, 32'd7, 32'd9}) begin
      n_fail++; $display("FAIL div_write: got hw=%b lw=%b hi=%h lo=%h, required 1/1/7/9", got.hi_we, got.lo_we, got.hi, got.lo);
    end
    check_quiet("div");
    // Flush while waiting: no retire, no HI/LO write.
    apply(in); bus.Div_Done = 0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    bus.W1_Flush = 1; #1;
    n_cmp++;
    if ({bus.W1_Stall, bus.W1_Issued} !== 2'b00) begin
      n_fail++; $display("FAIL div_flush_comb: got stall=%b issued=%b, required 0/0", bus.W1_Stall, bus.W1_Issued);
    end
    @(posedge clock); #1;
    idle();
    n_cmp++;
    if ({bus.W2_HiWrite, bus.W2_LoWrite} !== 2'b00) begin
      n_fail++; $display("FAIL div_flush_write: got hw=%b lw=%b, required 0/0", bus.W2_HiWrite, bus.W2_LoWrite);
    end
    check_quiet("div_flush");
  endtask

  task automatic test_icache_back_to_back();
    instr_t in; obs_t got; int st, gc, ic;
    in = nop_instr(); in.ic = 1;
    for (int k = 0; k < 2; k++) begin
      drive(in, 0, st, gc, ic, got);
      n_cmp++;
      if (st !== 1 || gc !== 1 || ic !== 1) begin
        n_fail++; $display("FAIL icache_seq%0d: got stalls=%0d go=%0d issue_cyc=%0d, required 1/1/1", k, st, gc, ic);
      end
    end
    check_quiet("icache");
  endtask

  task automatic test_simultaneous();
    instr_t in; obs_t got; int st, gc, ic;
    in = nop_instr(); in.div = 1; in.hw = 1; in.lw = 1; in.dhi = 32'hA5A5_0001; in.dlo = 32'h5A5A_0002;
    drive(in, 0, st, gc, ic, got);
    n_cmp++;
    if (st !== 0 || ic !== 0) begin n_fail++; $display("FAIL div_same_cycle: got stalls=%0d issue_cyc=%0d, required 0/0", st, ic); end
    n_cmp++;
    if ({got.hi, got.lo} !== {32'hA5A5_0001, 32'h5A5A_0002}) begin
      n_fail++; $display("FAIL div_same_cycle_data: got hi=%h lo=%h, required a5a50001/5a5a0002", got.hi, got.lo);
    end
    in = nop_instr(); in.exc = 1; in.code = 5'h0C; in.pc = 32'h40;
    apply(in); bus.W1_Flush = 1; #1;
    n_cmp++;
    if (bus.W1_Issued !== 1'b0) begin n_fail++; $display("FAIL flush_exc_issue: got W1_Issued=%b, required 0", bus.W1_Issued); end
    @(posedge clock); #1;
    idle();
    n_cmp++;
    if (bus.Exc_Valid !== 1'b0) begin n_fail++; $display("FAIL flush_exc: got Exc_Valid=%b, required 0", bus.Exc_Valid); end
  endtask

  task automatic test_random();
    instr_t in; obs_t got, e; int st, gc, ic, dd;
    for (int n = 0; n < 60; n++) begin
      in = nop_instr();
      in.exc = ($urandom_range(0, 5) == 0);
      in.code = 5'($urandom); in.pc = $urandom; in.bds = 1'($urandom); in.bva = $urandom;
      in.rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      in.rw = 1'($urandom); in.hw = 1'($urandom); in.lw = 1'($urandom); in.m2r = 1'($urandom);
      in.div = ($urandom_range(0, 3) == 0);
      in.ic = !in.div && ($urandom_range(0, 4) == 0);
      in.eret = ($urandom_range(0, 7) == 0);
      in.alu = $urandom; in.rdata = $urandom; in.dhi = $urandom; in.dlo = $urandom;
      dd = $urandom_range(0, 4);
      e = model(in);
      drive(in, dd, st, gc, ic, got);
      n_cmp++;
      if ({got.reg_we, got.hi_we, got.lo_we, got.exc, got.eret} !== {e.reg_we, e.hi_we, e.lo_we, e.exc, e.eret}) begin
        n_fail++; $display("FAIL rnd%0d_strobes: got %b, required %b", n,
          {got.reg_we, got.hi_we, got.lo_we, got.exc, got.eret}, {e.reg_we, e.hi_we, e.lo_we, e.exc, e.eret});
      end
      n_cmp++;
      if (st !== model_stalls(in, dd) || gc !== int'(in.ic && !in.exc)) begin
        n_fail++; $display("FAIL rnd%0d_timing: got stalls=%0d go=%0d, required %0d/%0d", n, st, gc,
                           model_stalls(in, dd), int'(in.ic && !in.exc));
      end
      if (e.reg_we) begin
        n_cmp++;
        if ({got.rd, got.wdata} !== {e.rd, e.wdata}) begin
          n_fail++; $display("FAIL rnd%0d_gpr: got rd=%0d wd=%h, required %0d/%h", n, got.rd, got.wdata, e.rd, e.wdata);
        end
      end
      if (e.hi_we || e.lo_we) begin
        n_cmp++;
        if ((e.hi_we && got.hi !== e.hi) || (e.lo_we && got.lo !== e.lo)) begin
          n_fail++; $display("FAIL rnd%0d_hilo: got hi=%h lo=%h, required %h/%h", n, got.hi, got.lo, e.hi, e.lo);
        end
      end
      if (e.exc) begin
        n_cmp++;
        if ({got.code, got.epc, got.bd, got.bva} !== {e.code, e.epc, e.bd, e.bva}) begin
          n_fail++; $display("FAIL rnd%0d_exc: got code=%h epc=%h bd=%b bva=%h, required %h/%h/%b/%h", n,
                             got.code, got.epc, got.bd, got.bva, e.code, e.epc, e.bd, e.bva);
        end
      end
      if ($urandom_range(0, 3) == 0) check_quiet("rnd");
    end
  endtask

  initial begin
    test_reset();
    test_normal_retire();
    test_exception();
    test_div_wait();
    test_icache_back_to_back();
    test_simultaneous();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/w1_commit.md
# w1_commit

Writeback commit controller at the consuming end of the M2→W1 pipeline register. Each cycle it decides whether the instruction held in W1 retires, stalls or traps, and drives the registered architectural-state write ports: GPR, HI/LO, exception commit and ERET commit. It also generates `W1_Stall` and `W1_Issued` back into the W1 register. This covers multi-cycle divide completion and the 2-cycle i-cache operation.

## Interface
Parameters:
- none

Ports (name, direction, width, meaning):
- `clock`  in  1  core clock
- `reset`  in  1  asynchronous, active-low reset
- `W1_M2Issued`  in  1  W1 holds a valid instruction
- `W1_Flush`  in  1  kill W1 contents this cycle
- `W1_M2Exception`  in  1  instruction carries an exception
- `W1_M2ExcCode`  in  5  exception code
- `W1_RestartPC`  in  32  restart PC of the W1 instruction
- `W1_IsBDS`  in  1  instruction is in a branch delay slot
- `W1_BadVAddr`  in  32  faulting address
- `W1_RtRd`  in  5  destination GPR
- `W1_RegWrite`, `W1_HiWrite`, `W1_LoWrite`, `W1_MemToReg`, `W1_Div`, `W1_ICacheOp`, `W1_Eret`  in  1 each  control bits
- `W1_ALUResult`, `W1_ReadData`  in  32  result sources
- `Div_Done`  in  1  divider result valid
- `Div_Hi`, `Div_Lo`  in  32  divider remainder and quotient
- `W1_Stall`  out  1  hold the W1 register
- `W1_Issued`  out  1  W1 instruction retires this cycle
- `ICache_Go`  out  1  i-cache operation launch, one-cycle pulse
- `W2_RegWrite`  out  1  GPR write strobe
- `W2_RtRd`  out  5  GPR write address
- `W2_WriteData`  out  32  GPR write data
- `W2_HiWrite`, `W2_LoWrite`  out  1 each  HI/LO write strobes
- `W2_Hi`, `W2_Lo`  out  32  HI/LO write data
- `Exc_Valid`  out  1  exception commit pulse
- `Exc_Code`  out  5  exception code
- `Exc_EPC`  out  32  exception PC
- `Exc_BD`  out  1  branch-delay flag
- `Exc_BadVAddr`  out  32  faulting address
- `Eret_Commit`  out  1  ERET retire pulse

## Operation
State register, 2 bits:
- **RUN**
  - `v = W1_M2Issued & ~W1_Flush`.
  - If `v & W1_M2Exception`, the instruction traps:
    - `W1_Issued = 1`.
    - Next cycle: `Exc_Valid = 1`, `Exc_EPC = W1_RestartPC`, `Exc_BD = W1_IsBDS`, and `Exc_Code` / `Exc_BadVAddr` captured from the inputs.
    - No GPR, HI or LO writes. Exception takes priority over Div, ICacheOp and Eret.
  - Else if `v & W1_Div & ~Div_Done`: assert `W1_Stall`, go to DIV_WAIT.
  - Else if `v & W1_ICacheOp`: pulse `ICache_Go`, assert `W1_Stall`, go to ICACHE2.
  - Else if `v`: retire. `W1_Issued = 1`, and the write ports are registered for next cycle.
- **DIV_WAIT**
  - Hold `W1_Stall = 1` until `Div_Done`.
  - On `Div_Done`: retire. `W2_HiWrite = W1_HiWrite`, `W2_Lo = Div_Lo`, `W2_Hi = Div_Hi`. Return to RUN.
  - `W1_Flush` aborts: no writes, return to RUN.
- **ICACHE2**
  - Second cycle of the i-cache operation.
  - `W1_Stall = 0`, `W1_Issued = 1`, return to RUN.
  - `W1_Flush` aborts the retire only. `ICache_Go` has already fired and is not recalled.

Write data rules:
- `W2_WriteData = W1_MemToReg ? W1_ReadData : W1_ALUResult`.
- `W2_RegWrite` is suppressed when `W1_RtRd == 0`.
- Non-div HI/LO writes take their data from `W1_ALUResult`.
- ERET retire pulses `Eret_Commit` for one cycle.
- All write strobes and pulses are single-cycle and registered.

## Timing
- Reset (async, active-low) forces:
  - state RUN;
  - all strobes and pulses 0: `W1_Stall`, `W1_Issued`, `ICache_Go`, `W2_RegWrite`, `W2_HiWrite`, `W2_LoWrite`, `Exc_Valid`, `Eret_Commit`;
  - all data outputs 0.
- Reset mid-DIV_WAIT or mid-ICACHE2 returns to RUN with no commit.
- Latencies:
  - Normal retire: writes appear 1 cycle after the `W1_Issued` cycle.
  - Divide: writes appear 1 cycle after `Div_Done`.
  - I-cache operation: 2 cycles in W1.
- `W1_Stall` and `W1_Issued` are combinational from state and inputs. They are never high in the same cycle.
- Flush has priority over every event in every state.
- `Div_Done` arriving in the same RUN cycle as the instruction retires it directly, with no DIV_WAIT visit.
- The registered write outputs reflect only instructions that did not trap, with no retirement gaps.

## Test plan
1. **Reset:** reset low mid-DIV_WAIT → all outputs 0, state RUN; first instruction after release retires normally.
2. **Normal retire:** `W1_M2Issued=1`, `W1_RegWrite=1`, `W1_RtRd=5`, `W1_MemToReg=1`, `W1_ReadData=32'hDEADBEEF` → next cycle `W2_RegWrite=1`, `W2_RtRd=5`, `W2_WriteData=32'hDEADBEEF`. Repeat with `W1_RtRd=0` → `W2_RegWrite=0`.
3. **Exception:** `W1_M2Exception=1`, `W1_M2ExcCode=5'h04`, `W1_RestartPC=32'h80000180`, `W1_IsBDS=1`, `W1_RegWrite=1` → `Exc_Valid` pulse, `Exc_EPC=32'h80000180`, `Exc_BD=1`, `Exc_Code=4`, no GPR write.
4. **Divide wait:** `W1_Div=1`, `Div_Done` rises 3 cycles later with `Div_Hi=7`, `Div_Lo=9` → `W1_Stall` high for exactly 3 cycles, then `W2_Hi=7`, `W2_Lo=9` strobed once. Repeat with `W1_Flush` in cycle 2 → no write.
5. **I-cache op:** `W1_ICacheOp=1` → `ICache_Go` for 1 cycle, `W1_Stall` for 1 cycle, `W1_Issued` in cycle 2; a back-to-back second i-cache op repeats the sequence exactly.
6. **Simultaneous events:** `Div_Done=1` together with a fresh `W1_Div` in RUN → immediate retire, `W1_Stall=0`. `W1_Flush=1` together with `W1_M2Exception=1` → `Exc_Valid=0`.
